sdram_port_arb: RTL and testbench
=================================

# sdram_port_arb

Three-client arbiter for one toggle-handshake SDRAM request port (the `portN_req`/`portN_ack`/`portN_q` style port of the MiST `sdram` controller). It sits between the controller and the system's bursty 16-bit clients: ROM downloader, CPU work RAM and video-RAM copy engine. Each client gets a simple level-request/pulse-ack handshake. The arbiter grants one client at a time in round-robin order, owns the toggle protocol, and returns read data to the granted client.

## Interface
Parameters:
- AW, 23, word-address width (`sd_a` is [AW:1])
- DW, 16, data width

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller
- reset  in  1  reset, synchronous, active-high
- cli_req  in  3  per-client level request; held high until the matching `cli_ack`
- cli_we  in  3  per-client write enable; 0 = read
- cli_a  in  3×AW  per-client word address
- cli_ds  in  3×2  per-client byte strobes, {upper, lower}
- cli_d  in  3×DW  per-client write data
- cli_ack  out  3  one-cycle completion pulse per client
- cli_q  out  DW  read data; valid in the `cli_ack` cycle, held until the next completion
- sd_req  out  1  toggle request to the controller
- sd_ack  in  1  controller ack; equals `sd_req` when the access is done
- sd_we, sd_a, sd_ds, sd_d  out  1/AW/2/DW  latched command fields to the controller
- sd_q  in  DW  controller read data

## Operation
State machine with four states: IDLE, WAIT, DONE, DRAIN.

- **IDLE**
  - If any `cli_req` bit is set, pick grant `g` round-robin: search order is `ptr`, `ptr+1`, `ptr+2` (mod 3).
  - Latch `g` and its `cli_we/a/ds/d` into the `sd_*` registers and toggle `sd_req`.
  - Set `ptr <= (g+1) mod 3` and go to WAIT.
- **WAIT**
  - Hold all `sd_*` fields stable.
  - When `sd_ack == sd_req`: register `cli_q <= sd_q` (reads only; `cli_q` is unchanged on writes), pulse `cli_ack[g]`, go to DONE.
- **DONE**
  - Lasts exactly one cycle and issues no grant, so client `g` can drop `cli_req[g]` before the next arbitration.
  - Return to IDLE.
- **DRAIN**
  - Entered from reset when `sd_req != sd_ack`, i.e. an access is in flight.
  - Wait for `sd_ack == sd_req`, then go to IDLE. No `cli_ack` and no `cli_q` update.

Reset behaviour:
- `sd_req` is never forced by reset; its power-up value is 0 via register initialiser. This keeps it consistent with the controller's request state.
- During reset, the state is IDLE if `sd_req == sd_ack`, otherwise DRAIN.
- Other reset values: `ptr` = 0, `cli_ack` = 0, `cli_q` = 0, `sd_we` = 0, `sd_a` = 0, `sd_ds` = 2'b11, `sd_d` = 0.

Boundary conditions:
- Simultaneous requests from all clients with `ptr` = 0 are served in the order 0, 1, 2.
- A client that re-asserts `cli_req` in the cycle after DONE is eligible again, but only after the other pending clients by round robin.
- A client that drops `cli_req` before being granted is simply skipped; a request is not retracted once granted.
- `sd_ack` toggling while in IDLE or DONE is ignored.

## Timing
- Cycle n: `cli_req` sampled high in IDLE. Cycle n+1: `sd_req` toggled and `sd_*` fields valid.
- Controller ack seen at cycle m gives `cli_ack` and `cli_q` at m+1.
- Arbiter overhead: 3 cycles per access (issue, ack register, DONE).
- Minimum back-to-back spacing between grants = controller latency + 3 cycles.
- `sd_*` fields are stable from the `sd_req` toggle until the ack; the controller may sample them at any point in that window.
- All outputs are registered; there are no combinational paths from client inputs to `sd_*`.

## Structure
- Package `sdram_arb_pkg` holds:
  - the state enum `{IDLE, WAIT, DONE, DRAIN}`;
  - `NCLI = 3`;
  - a client command struct `{we, a, ds, d}`.
- One sub-module, `rr_pick3`: combinational round-robin selector taking `req[2:0]` and `ptr[1:0]` and returning `gnt[1:0]` and `any`.
- Everything else is in `sdram_port_arb`.

## Test plan
- Single read:
  - Stimulus: client 1 reads `a` = 0x000123; controller model acks after 7 cycles with `sd_q` = 0xBEEF.
  - Required: `sd_req` toggles once; `cli_ack[1]` pulses at ack+1 with `cli_q` = 0xBEEF; `sd_a` = 0x000123 throughout.
- Three-way contention:
  - Stimulus: all `cli_req` rise in the same cycle after reset.
  - Required: grants 0, 1, 2 in order; exactly three `sd_req` toggles; each `cli_ack` is a single pulse.
- Round-robin fairness:
  - Stimulus: client 0 re-requests continuously while client 2 is pending.
  - Required: client 2 is served on the second grant, never starved.
- Write:
  - Stimulus: client 2 writes `d` = 0x55AA, `ds` = 2'b01.
  - Required: `sd_we` = 1 and `sd_ds` = 01 held until ack; `cli_q` keeps its previous value.
- Reset mid-access:
  - Stimulus: assert reset 2 cycles after `sd_req` toggles; controller acks 5 cycles later.
  - Required: DRAIN is entered; no `cli_ack`; `sd_req` unchanged; the first new grant follows the ack.
- Early-drop and stale-ack robustness:
  - Stimulus: client 1 pulses `cli_req` for 1 cycle while client 0 is in WAIT and then drops it; separately, force a spurious `sd_ack` edge in IDLE.
  - Required: no grant for client 1, and no `cli_ack` in either case.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb_pkg
// Purpose  : Shared types for the three-client SDRAM port arbiter: FSM state
//            encoding, client count, latched client command record and the
//            mod-3 round-robin increment.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

  localparam int NCLI   = 3;
  localparam int CMD_AW = 23;
  localparam int CMD_DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  // One client command as presented to the controller.
  typedef struct packed {
    logic              we;
    logic [CMD_AW-1:0] a;
    logic [1:0]        ds;
    logic [CMD_DW-1:0] d;
  } cli_cmd_t;

  // Next client index in round-robin order (0 -> 1 -> 2 -> 0).
  function automatic logic [1:0] rr_next(input logic [1:0] x);
    return (x >= 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_port_arb_rr_pick3.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick3
// Purpose  : Combinational round-robin selector for three requesters.
//            Search order is ptr, ptr+1, ptr+2 (mod 3).
// Ports    : req[2:0] request vector, ptr[1:0] highest-priority index,
//            gnt[1:0] selected index (meaningful only when any = 1),
//            any      at least one request present.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt,
  output logic       any
);

  always_comb begin
    any = |req;
    gnt = 2'd0;
    case (ptr)
      2'd1:    gnt = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd2:    gnt = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: gnt = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arb
// Purpose  : Round-robin arbiter sharing one toggle-handshake SDRAM port
//            between three level-request / pulse-ack clients.
// Ports    : clk, reset           clock, synchronous active-high reset
//            cli_req/we/a/ds/d    per-client request and command (packed,
//                                 client i at slice i)
//            cli_ack              one-cycle completion pulse per client
//            cli_q                read data, held until the next read
//            sd_req / sd_ack      toggle request / ack to the controller
//            sd_we/a/ds/d, sd_q   latched command fields, controller data
// Note     : AW/DW must equal CMD_AW/CMD_DW of the package record.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int AW = CMD_AW,
  parameter int DW = CMD_DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCLI-1:0]    cli_req,
  input  logic [NCLI-1:0]    cli_we,
  input  logic [NCLI*AW-1:0] cli_a,
  input  logic [NCLI*2-1:0]  cli_ds,
  input  logic [NCLI*DW-1:0] cli_d,
  output logic [NCLI-1:0]    cli_ack,
  output logic [DW-1:0]      cli_q,
  output logic               sd_req,
  input  logic               sd_ack,
  output logic               sd_we,
  output logic [AW:1]        sd_a,
  output logic [1:0]         sd_ds,
  output logic [DW-1:0]      sd_d,
  input  logic [DW-1:0]      sd_q
);

  localparam logic [NCLI-1:0] c_ack_one = NCLI'(1);

  arb_state_t      r_state;
  logic [1:0]      r_ptr;
  logic [1:0]      r_gnt;
  logic [NCLI-1:0] r_ack;
  logic [DW-1:0]   r_q;
  cli_cmd_t        r_cmd;
  // Deliberately outside reset: the controller keeps its own copy of the
  // request phase, so forcing this bit would fake or swallow an access.
  logic            r_sd_req = 1'b0;

  logic [1:0]      w_pick;
  logic            w_any;
  cli_cmd_t        w_sel;

  rr_pick3 u_pick (
    .req (cli_req),
    .ptr (r_ptr),
    .gnt (w_pick),
    .any (w_any)
  );

  // Command fields of the client the selector is pointing at.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NCLI; i++) begin
      if (w_pick == i[1:0]) begin
        w_sel.we = cli_we[i];
        w_sel.a  = cli_a[i*AW +: AW];
        w_sel.ds = cli_ds[i*2 +: 2];
        w_sel.d  = cli_d[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // An access still in flight must finish before new grants are issued.
      r_state  <= (r_sd_req == sd_ack) ? IDLE : DRAIN;
      r_ptr    <= 2'd0;
      r_gnt    <= 2'd0;
      r_ack    <= '0;
      r_q      <= '0;
      r_cmd.we <= 1'b0;
      r_cmd.a  <= '0;
      r_cmd.ds <= 2'b11;
      r_cmd.d  <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt    <= w_pick;
            r_cmd    <= w_sel;
            r_sd_req <= ~r_sd_req;
            r_ptr    <= rr_next(w_pick);
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (sd_ack == r_sd_req) begin
            if (!r_cmd.we) r_q <= sd_q;
            r_ack   <= c_ack_one << r_gnt;
            r_state <= DONE;
          end
        end
        // Gap cycle so the served client can drop its request in time.
        DONE:    r_state <= IDLE;
        DRAIN: begin
          if (sd_ack == r_sd_req) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sd_req  = r_sd_req;
  assign sd_we   = r_cmd.we;
  assign sd_a    = r_cmd.a;
  assign sd_ds   = r_cmd.ds;
  assign sd_d    = r_cmd.d;
  assign cli_ack = r_ack;
  assign cli_q   = r_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arb
// Purpose  : Scoreboard bench for sdram_port_arb. Directed stimulus pushes
//            expected controller commands and client responses into queues;
//            a monitor pops and compares whenever the DUT toggles sd_req or
//            pulses cli_ack. A toggle-protocol controller model answers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arb;

  localparam int AW = 23;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [2:0]      cli_req = '0;
  logic [2:0]      cli_we = '0;
  logic [3*AW-1:0] cli_a = '0;
  logic [5:0]      cli_ds = 6'b111111;
  logic [3*DW-1:0] cli_d = '0;
  logic [2:0]      cli_ack;
  logic [DW-1:0]   cli_q;
  logic            sd_req;
  logic            sd_ack = 1'b0;
  logic            sd_we;
  logic [AW:1]     sd_a;
  logic [1:0]      sd_ds;
  logic [DW-1:0]   sd_d;
  logic [DW-1:0]   sd_q = '0;

  always #5 clk = ~clk;

  sdram_port_arb #(.AW(AW), .DW(DW)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .cli_req (cli_req),
    .cli_we  (cli_we),
    .cli_a   (cli_a),
    .cli_ds  (cli_ds),
    .cli_d   (cli_d),
    .cli_ack (cli_ack),
    .cli_q   (cli_q),
    .sd_req  (sd_req),
    .sd_ack  (sd_ack),
    .sd_we   (sd_we),
    .sd_a    (sd_a),
    .sd_ds   (sd_ds),
    .sd_d    (sd_d),
    .sd_q    (sd_q)
  );

  int checks = 0;
  int errors = 0;

  logic [41:0] exp_cmd[$];   // {we, a, ds, d} in expected grant order
  logic [17:0] exp_rsp[$];   // {client, cli_q} in expected completion order
  logic [15:0] model_q[$];   // data the controller returns, one per access

  int  lat      = 7;
  bit  model_en = 1'b1;
  int  mcnt     = 0;
  int  toggles  = 0;
  int  reps[3]  = '{0, 0, 0};
  bit  rearm[3] = '{0, 0, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [41:0] cmd(input logic we, input logic [22:0] a,
                                      input logic [1:0] ds, input logic [15:0] d);
    return {we, a, ds, d};
  endfunction

  task automatic set_cli(input int i, input logic we, input logic [22:0] a,
                         input logic [1:0] ds, input logic [15:0] d);
    cli_we[i]          = we;
    cli_a[i*AW +: AW]  = a;
    cli_ds[i*2 +: 2]   = ds;
    cli_d[i*DW +: DW]  = d;
  endtask

  // Controller model: acks `lat` cycles after seeing a pending toggle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (model_en && sd_req !== sd_ack) begin
        mcnt++;
        if (mcnt >= lat) begin
          sd_q   = (model_q.size() != 0) ? model_q.pop_front() : 16'hDEAD;
          sd_ack = sd_req;
          mcnt   = 0;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  // Client behaviour: drop request on ack, optionally re-request next cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rearm[i]) begin
          cli_req[i] = 1'b1;
          rearm[i]   = 1'b0;
        end else if (cli_ack[i]) begin
          cli_req[i] = 1'b0;
          if (reps[i] > 0) begin
            reps[i]--;
            rearm[i] = 1'b1;
          end
        end
      end
    end
  end

  // Monitor / scoreboard.
  logic        p_req = 1'b0;
  logic        p_ack = 1'b0;
  logic [2:0]  p_cli_ack = '0;
  logic [41:0] cur_cmd = '0;
  bit          inflight = 1'b0;
  logic [15:0] last_q = '0;
  logic [1:0]  mon_idx;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        last_q    = '0;
        inflight  = 1'b0;
        p_cli_ack = '0;
      end else begin
        if (sd_req !== p_req) begin
          toggles++;
          chk("issue_while_busy", {63'd0, p_ack == p_req}, 64'd1);
          if (exp_cmd.size() == 0) fail_now("unexpected_grant");
          else chk("sd_cmd", {22'd0, sd_we, sd_a, sd_ds, sd_d}, {22'd0, exp_cmd.pop_front()});
          inflight = 1'b1;
          cur_cmd  = {sd_we, sd_a, sd_ds, sd_d};
        end else if (inflight && sd_req !== sd_ack) begin
          chk("sd_stable", {22'd0, sd_we, sd_a, sd_ds, sd_d}, {22'd0, cur_cmd});
        end
        if (sd_req === sd_ack) inflight = 1'b0;

        if (cli_ack !== 3'b000) begin
          chk("ack_onehot", {63'd0, $onehot(cli_ack)}, 64'd1);
          chk("ack_single", {61'd0, cli_ack & p_cli_ack}, 64'd0);
          mon_idx = cli_ack[0] ? 2'd0 : (cli_ack[1] ? 2'd1 : 2'd2);
          if (exp_rsp.size() == 0) fail_now("unexpected_ack");
          else chk("rsp", {46'd0, mon_idx, cli_q}, {46'd0, exp_rsp.pop_front()});
          last_q = cli_q;
        end else begin
          chk("q_hold", {48'd0, cli_q}, {48'd0, last_q});
        end
        p_cli_ack = cli_ack;
      end
      p_req = sd_req;
      p_ack = sd_ack;
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_cmd.size() != 0 || exp_rsp.size() != 0 || sd_req !== sd_ack ||
            cli_req != 3'b000) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      fail_now({name, "_timeout"});
      exp_cmd.delete();
      exp_rsp.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_toggle(input string name);
    int n = 0;
    while (sd_req === sd_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now({name, "_no_issue"});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  int   t0;
  logic saved_req;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sd_req",  {63'd0, sd_req}, 64'd0);
    chk("rst_sd_we",   {63'd0, sd_we},  64'd0);
    chk("rst_sd_a",    {41'd0, sd_a},   64'd0);
    chk("rst_sd_ds",   {62'd0, sd_ds},  64'd3);
    chk("rst_sd_d",    {48'd0, sd_d},   64'd0);
    chk("rst_cli_ack", {61'd0, cli_ack}, 64'd0);
    chk("rst_cli_q",   {48'd0, cli_q},  64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single read by client 1.
    set_cli(1, 1'b0, 23'h000123, 2'b11, 16'h0000);
    model_q.push_back(16'hBEEF);
    exp_cmd.push_back(cmd(1'b0, 23'h000123, 2'b11, 16'h0000));
    exp_rsp.push_back({2'd1, 16'hBEEF});
    t0 = toggles;
    cli_req[1] = 1'b1;
    wait_done("single_read");
    chk("single_read_toggles", 64'(toggles - t0), 64'd1);
    chk("single_read_q", {48'd0, cli_q}, 64'hBEEF);

    // Three-way contention straight after reset: order 0, 1, 2.
    do_reset();
    set_cli(0, 1'b0, 23'h000010, 2'b11, 16'h0000);
    set_cli(1, 1'b0, 23'h000020, 2'b11, 16'h0000);
    set_cli(2, 1'b0, 23'h000030, 2'b11, 16'h0000);
    model_q.push_back(16'h1111);
    model_q.push_back(16'h2222);
    model_q.push_back(16'h3333);
    exp_cmd.push_back(cmd(1'b0, 23'h000010, 2'b11, 16'h0000));
    exp_cmd.push_back(cmd(1'b0, 23'h000020, 2'b11, 16'h0000));
    exp_cmd.push_back(cmd(1'b0, 23'h000030, 2'b11, 16'h0000));
    exp_rsp.push_back({2'd0, 16'h1111});
    exp_rsp.push_back({2'd1, 16'h2222});
    exp_rsp.push_back({2'd2, 16'h3333});
    t0 = toggles;
    cli_req = 3'b111;
    wait_done("contention");
    chk("contention_toggles", 64'(toggles - t0), 64'd3);

    // Fairness: client 0 re-requests immediately, client 2 is served second.
    set_cli(0, 1'b0, 23'h000040, 2'b11, 16'h0000);
    set_cli(2, 1'b0, 23'h000050, 2'b11, 16'h0000);
    reps[0] = 1;
    model_q.push_back(16'hA001);
    model_q.push_back(16'hA002);
    model_q.push_back(16'hA003);
    exp_cmd.push_back(cmd(1'b0, 23'h000040, 2'b11, 16'h0000));
    exp_cmd.push_back(cmd(1'b0, 23'h000050, 2'b11, 16'h0000));
    exp_cmd.push_back(cmd(1'b0, 23'h000040, 2'b11, 16'h0000));
    exp_rsp.push_back({2'd0, 16'hA001});
    exp_rsp.push_back({2'd2, 16'hA002});
    exp_rsp.push_back({2'd0, 16'hA003});
    t0 = toggles;
    cli_req = 3'b101;
    wait_done("fairness");
    chk("fairness_toggles", 64'(toggles - t0), 64'd3);

    // Write by client 2: cli_q keeps the previous read value.
    set_cli(2, 1'b1, 23'h000060, 2'b01, 16'h55AA);
    model_q.push_back(16'hFFFF);
    exp_cmd.push_back(cmd(1'b1, 23'h000060, 2'b01, 16'h55AA));
    exp_rsp.push_back({2'd2, 16'hA003});
    t0 = toggles;
    cli_req[2] = 1'b1;
    wait_done("write");
    chk("write_toggles", 64'(toggles - t0), 64'd1);
    chk("write_q_kept", {48'd0, cli_q}, 64'hA003);

    // Reset while an access is in flight: drain, then a fresh grant.
    set_cli(0, 1'b0, 23'h000070, 2'b11, 16'h0000);
    set_cli(1, 1'b0, 23'h000080, 2'b11, 16'h0000);
    lat = 9;
    model_q.push_back(16'h7777);
    model_q.push_back(16'h8888);
    exp_cmd.push_back(cmd(1'b0, 23'h000070, 2'b11, 16'h0000));
    exp_cmd.push_back(cmd(1'b0, 23'h000080, 2'b11, 16'h0000));
    exp_rsp.push_back({2'd1, 16'h8888});
    t0 = toggles;
    cli_req[0] = 1'b1;
    wait_toggle("reset_mid");
    repeat (2) @(negedge clk);
    reset      = 1'b1;
    cli_req[0] = 1'b0;
    saved_req  = sd_req;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("drain_sd_req_kept", {63'd0, sd_req}, {63'd0, saved_req});
    cli_req[1] = 1'b1;
    wait_done("reset_mid");
    lat = 7;
    chk("reset_mid_toggles", 64'(toggles - t0), 64'd2);
    chk("reset_mid_q", {48'd0, cli_q}, 64'h8888);

    // Client 1 pulses its request while client 0 waits on the controller.
    set_cli(0, 1'b0, 23'h000090, 2'b11, 16'h0000);
    set_cli(1, 1'b0, 23'h0000A0, 2'b11, 16'h0000);
    model_q.push_back(16'h9999);
    exp_cmd.push_back(cmd(1'b0, 23'h000090, 2'b11, 16'h0000));
    exp_rsp.push_back({2'd0, 16'h9999});
    t0 = toggles;
    cli_req[0] = 1'b1;
    wait_toggle("early_drop");
    @(negedge clk);
    cli_req[1] = 1'b1;
    @(negedge clk);
    cli_req[1] = 1'b0;
    wait_done("early_drop");
    chk("early_drop_toggles", 64'(toggles - t0), 64'd1);

    // Spurious controller ack edge while idle.
    t0 = toggles;
    model_en = 1'b0;
    @(posedge clk);
    #2 sd_ack = ~sd_ack;
    @(posedge clk);
    #2 sd_ack = ~sd_ack;
    model_en = 1'b1;
    repeat (8) @(negedge clk);
    chk("spurious_toggles", 64'(toggles - t0), 64'd0);
    chk("spurious_q", {48'd0, cli_q}, 64'h9999);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    fail_now("global_timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
